// File: rtl/adpll_pkg.sv
// Shared definitions for the ADPLL modulation data source: loop mode codes,
// data source selections, sequencer state encoding and PRBS9 constants.
package adpll_pkg;

    localparam logic [1:0] MODE_PD   = 2'd0;
    localparam logic [1:0] MODE_TEST = 2'd1;
    localparam logic [1:0] MODE_RX   = 2'd2;
    localparam logic [1:0] MODE_TX   = 2'd3;

    localparam logic [1:0] SRC_ZERO    = 2'd0;
    localparam logic [1:0] SRC_ALT     = 2'd1;
    localparam logic [1:0] SRC_PRBS9   = 2'd2;
    localparam logic [1:0] SRC_PAYLOAD = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    // x^9 + x^5 + 1: feedback taken from bits 8 and 4
    localparam int         PRBS9_TAP_HI       = 8;
    localparam int         PRBS9_TAP_LO       = 4;
    localparam logic [8:0] PRBS9_DEFAULT_SEED = 9'h1FF;

endpackage

// File: rtl/adpll_mod_gen_if.sv
// Payload word handshake between the CPU register file (master) and the
// modulation data source (slave).
//   payload        master->slave  payload word, shifted MSB first
//   payload_valid  master->slave  word offered
//   payload_ready  slave->master  holding register empty
interface adpll_mod_gen_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] payload;
    logic              payload_valid;
    logic              payload_ready;

    modport master (output payload, output payload_valid, input payload_ready);
    modport slave  (input payload, input payload_valid, output payload_ready);
endinterface

// File: rtl/adpll_prbs9.sv
// 9-bit Fibonacci LFSR for x^9 + x^5 + 1.
//   i_clk   system clock
//   i_rst   synchronous active-low reset
//   i_load  load i_seed (all-zero seed is replaced by the default seed)
//   i_seed  seed value
//   i_adv   advance one step
//   o_out   current output bit, lfsr[8]
module adpll_prbs9
    import adpll_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_load,
    input  logic [8:0] i_seed,
    input  logic       i_adv,
    output logic       o_out
);

    logic [8:0] r_lfsr;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_lfsr <= PRBS9_DEFAULT_SEED;
        end else if (i_load) begin
            // the all-zero state is a lock-up state for this LFSR
            r_lfsr <= (i_seed == 9'd0) ? PRBS9_DEFAULT_SEED : i_seed;
        end else if (i_adv) begin
            r_lfsr <= {r_lfsr[7:0], r_lfsr[PRBS9_TAP_HI] ^ r_lfsr[PRBS9_TAP_LO]};
        end
    end

    assign o_out = r_lfsr[8];

endmodule

// File: rtl/adpll_mod_gen.sv
// Transmit modulation data source for the ADPLL. Emits one data_mod symbol
// every (sym_period+1) clocks while enabled, in TX mode and locked.
//   i_clk, i_rst     system clock, synchronous active-low reset
//   i_en             block enable
//   i_adpll_mode     loop mode (PD/TEST/RX/TX)
//   i_channel_lock   ADPLL lock indication
//   i_sym_period     clocks per symbol minus 1 (latched on RUN entry)
//   i_src_sel        zero / alternating / PRBS9 / payload (latched)
//   i_seed           PRBS9 seed (loaded on RUN entry)
//   pl_if            payload valid/ready handshake into the holding register
//   o_data_mod       modulation bit
//   o_sym_strobe     one-cycle pulse on each data_mod update
//   o_busy           state is RUN
//   o_underflow      sticky: payload exhausted in RUN
//   o_bit_count      symbols emitted since RUN entry
//
// state | meaning
// IDLE  | disabled or loop not in TX
// ARM   | enabled in TX, waiting for channel lock
// RUN   | emitting symbols
module adpll_mod_gen
    import adpll_pkg::*;
#(
    parameter int SYM_CNT_W = 5,
    parameter int DATA_W    = 32,
    parameter int BCNT_W    = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_en,
    input  logic [1:0]           i_adpll_mode,
    input  logic                 i_channel_lock,
    input  logic [SYM_CNT_W-1:0] i_sym_period,
    input  logic [1:0]           i_src_sel,
    input  logic [8:0]           i_seed,
    adpll_mod_gen_if.slave       pl_if,
    output logic                 o_data_mod,
    output logic                 o_sym_strobe,
    output logic                 o_busy,
    output logic                 o_underflow,
    output logic [BCNT_W-1:0]    o_bit_count
);

    localparam int SCNT_W = $clog2(DATA_W + 1);

    state_t                r_state;
    state_t                w_state_nxt;

    logic [SYM_CNT_W-1:0]  r_period;
    logic [SYM_CNT_W-1:0]  r_sym_cnt;
    logic [1:0]            r_src;
    logic                  r_alt;
    logic                  r_data_mod;
    logic                  r_strobe;
    logic                  r_busy;
    logic                  r_underflow;
    logic [BCNT_W-1:0]     r_bit_count;

    logic [DATA_W-1:0]     r_hold;
    logic                  r_hold_full;
    logic                  r_ready;
    logic [DATA_W-1:0]     r_shift;
    logic [SCNT_W-1:0]     r_scnt;

    logic                  w_go_idle;
    logic                  w_entry;
    logic                  w_stay;
    logic                  w_strobe;
    logic                  w_bit;
    logic                  w_prbs_out;
    logic                  w_shift_empty;
    logic                  w_shift_consume;
    logic                  w_underflow_evt;
    logic                  w_accept;
    logic                  w_xfer;
    logic                  w_hold_full_nxt;

    // state register
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // next state; dropping to IDLE overrides everything else
    assign w_go_idle = !i_en || (i_adpll_mode != MODE_TX);

    always_comb begin
        w_state_nxt = r_state;
        if (w_go_idle) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: w_state_nxt = ST_ARM;
                ST_ARM:  w_state_nxt = i_channel_lock ? ST_RUN : ST_ARM;
                ST_RUN:  w_state_nxt = i_channel_lock ? ST_RUN : ST_ARM;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // per-cycle controls derived from current and next state
    always_comb begin
        w_entry         = (r_state != ST_RUN) && (w_state_nxt == ST_RUN);
        w_stay          = (r_state == ST_RUN) && (w_state_nxt == ST_RUN);
        // a strobe due on the edge that leaves RUN is suppressed
        w_strobe        = w_stay && (r_sym_cnt == r_period);
        w_shift_empty   = (r_scnt == '0);
        w_shift_consume = w_strobe && (r_src == SRC_PAYLOAD) && !w_shift_empty;
        w_underflow_evt = w_strobe && (r_src == SRC_PAYLOAD) && w_shift_empty;
        w_accept        = pl_if.payload_valid && r_ready;
        // refill when empty, or when the current strobe takes the last bit
        w_xfer          = r_hold_full && (w_entry || w_stay) &&
                          (w_shift_empty || (w_shift_consume && (r_scnt == SCNT_W'(1))));
        // the transfer frees holding before a same-edge accept refills it
        w_hold_full_nxt = w_accept ? 1'b1 : (w_xfer ? 1'b0 : r_hold_full);

        w_bit = 1'b0;
        case (r_src)
            SRC_ZERO:    w_bit = 1'b0;
            SRC_ALT:     w_bit = r_alt;
            SRC_PRBS9:   w_bit = w_prbs_out;
            SRC_PAYLOAD: w_bit = w_shift_empty ? 1'b0 : r_shift[DATA_W-1];
            default:     w_bit = 1'b0;
        endcase
    end

    adpll_prbs9 u_prbs9 (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_load (w_entry),
        .i_seed (i_seed),
        .i_adv  (w_strobe && (r_src == SRC_PRBS9)),
        .o_out  (w_prbs_out)
    );

    // symbol timing and registered outputs
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_period    <= '0;
            r_src       <= SRC_ZERO;
            r_sym_cnt   <= '0;
            r_alt       <= 1'b1;
            r_data_mod  <= 1'b0;
            r_strobe    <= 1'b0;
            r_busy      <= 1'b0;
            r_underflow <= 1'b0;
            r_bit_count <= '0;
        end else begin
            r_busy <= (w_state_nxt == ST_RUN);
            if (w_entry) begin
                r_period    <= i_sym_period;
                r_src       <= i_src_sel;
                r_sym_cnt   <= '0;
                r_alt       <= 1'b1;
                r_data_mod  <= 1'b0;
                r_strobe    <= 1'b0;
                r_underflow <= 1'b0;
                r_bit_count <= '0;
            end else if (w_stay) begin
                if (w_strobe) begin
                    r_sym_cnt   <= '0;
                    r_strobe    <= 1'b1;
                    r_data_mod  <= w_bit;
                    r_bit_count <= r_bit_count + BCNT_W'(1);
                    if (r_src == SRC_ALT) begin
                        r_alt <= ~r_alt;
                    end
                    if (w_underflow_evt) begin
                        r_underflow <= 1'b1;
                    end
                end else begin
                    r_sym_cnt <= r_sym_cnt + SYM_CNT_W'(1);
                    r_strobe  <= 1'b0;
                end
            end else begin
                r_sym_cnt  <= '0;
                r_strobe   <= 1'b0;
                r_data_mod <= 1'b0;
            end
        end
    end

    // payload double buffer
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_ready     <= 1'b1;
            r_shift     <= '0;
            r_scnt      <= '0;
        end else begin
            if (w_xfer) begin
                r_shift <= r_hold;
                r_scnt  <= SCNT_W'(DATA_W);
            end else if ((r_state == ST_RUN) && !w_stay) begin
                r_scnt <= '0;
            end else if (w_shift_consume) begin
                r_shift <= {r_shift[DATA_W-2:0], 1'b0};
                r_scnt  <= r_scnt - SCNT_W'(1);
            end

            if (w_accept) begin
                r_hold <= pl_if.payload;
            end
            r_hold_full <= w_hold_full_nxt;
            r_ready     <= !w_hold_full_nxt;
        end
    end

    assign pl_if.payload_ready = r_ready;
    assign o_data_mod          = r_data_mod;
    assign o_sym_strobe        = r_strobe;
    assign o_busy              = r_busy;
    assign o_underflow         = r_underflow;
    assign o_bit_count         = r_bit_count;

endmodule

// File: tb/tb_adpll_mod_gen.sv
module tb_adpll_mod_gen;
    import adpll_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [1:0]  mode;
    logic        lock;
    logic [4:0]  sym_period;
    logic [1:0]  src_sel;
    logic [8:0]  seed;
    logic        data_mod;
    logic        sym_strobe;
    logic        busy;
    logic        underflow;
    logic [15:0] bit_count;

    int checks = 0;
    int errors = 0;

    adpll_mod_gen_if #(.DATA_W(32)) pl_if ();

    adpll_mod_gen #(.SYM_CNT_W(5), .DATA_W(32), .BCNT_W(16)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_en           (en),
        .i_adpll_mode   (mode),
        .i_channel_lock (lock),
        .i_sym_period   (sym_period),
        .i_src_sel      (src_sel),
        .i_seed         (seed),
        .pl_if          (pl_if),
        .o_data_mod     (data_mod),
        .o_sym_strobe   (sym_strobe),
        .o_busy         (busy),
        .o_underflow    (underflow),
        .o_bit_count    (bit_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic [1:0]  mode;
        logic        lock;
        logic        busy;
        logic        strobe;
        logic        dm;
        logic [15:0] bcnt;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle();
        en   = 1'b0;
        lock = 1'b1;
        mode = MODE_TX;
        tick();
        tick();
    endtask

    // IDLE -> ARM -> RUN; returns just after the RUN-entry edge
    task automatic start_run(input logic [1:0] s, input logic [4:0] p, input logic [8:0] sd);
        src_sel    = s;
        sym_period = p;
        seed       = sd;
        en         = 1'b1;
        mode       = MODE_TX;
        lock       = 1'b1;
        tick();
        tick();
    endtask

    task automatic wait_strobe(input int limit, output int cycles);
        cycles = -1;
        for (int n = 1; n <= limit; n++) begin
            tick();
            if (sym_strobe) begin
                cycles = n;
                break;
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cyc;
        int          nstrobe;
        logic [8:0]  m;
        logic [31:0] word;

        //           en    mode     lock  busy  strb  dm    bcnt
        vecs[0]  = '{1'b1, MODE_TX, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0};
        vecs[1]  = '{1'b1, MODE_TX, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0};
        vecs[2]  = '{1'b1, MODE_TX, 1'b1, 1'b1, 1'b1, 1'b1, 16'd1};
        vecs[3]  = '{1'b1, MODE_TX, 1'b1, 1'b1, 1'b1, 1'b0, 16'd2};
        vecs[4]  = '{1'b1, MODE_TX, 1'b1, 1'b1, 1'b1, 1'b1, 16'd3};
        vecs[5]  = '{1'b1, MODE_TX, 1'b0, 1'b0, 1'b0, 1'b0, 16'd3};
        vecs[6]  = '{1'b1, MODE_TX, 1'b0, 1'b0, 1'b0, 1'b0, 16'd3};
        vecs[7]  = '{1'b1, MODE_TX, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0};
        vecs[8]  = '{1'b1, MODE_TX, 1'b1, 1'b1, 1'b1, 1'b1, 16'd1};
        vecs[9]  = '{1'b1, MODE_RX, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1};
        vecs[10] = '{1'b1, MODE_RX, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1};
        vecs[11] = '{1'b0, MODE_TX, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1};
        vecs[12] = '{1'b1, MODE_TX, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1};
        vecs[13] = '{1'b1, MODE_TX, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0};
        vecs[14] = '{1'b1, MODE_TX, 1'b1, 1'b1, 1'b1, 1'b1, 16'd1};
        vecs[15] = '{1'b0, MODE_TX, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1};

        rst                 = 1'b0;
        en                  = 1'b0;
        mode                = MODE_PD;
        lock                = 1'b0;
        sym_period          = 5'd0;
        src_sel             = SRC_ALT;
        seed                = 9'd0;
        pl_if.payload       = 32'd0;
        pl_if.payload_valid = 1'b0;
        tick();
        tick();
        chk("rst_data_mod", {31'd0, data_mod}, 32'd0);
        chk("rst_strobe", {31'd0, sym_strobe}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_underflow", {31'd0, underflow}, 32'd0);
        chk("rst_bit_count", {16'd0, bit_count}, 32'd0);
        chk("rst_ready", {31'd0, pl_if.payload_ready}, 32'd1);
        rst = 1'b1;

        // FSM walk with alternating source, one symbol per clock
        for (int i = 0; i < 16; i++) begin
            en   = vecs[i].en;
            mode = vecs[i].mode;
            lock = vecs[i].lock;
            tick();
            chk($sformatf("vec%0d_busy", i), {31'd0, busy}, {31'd0, vecs[i].busy});
            chk($sformatf("vec%0d_strobe", i), {31'd0, sym_strobe}, {31'd0, vecs[i].strobe});
            chk($sformatf("vec%0d_data_mod", i), {31'd0, data_mod}, {31'd0, vecs[i].dm});
            chk($sformatf("vec%0d_bit_count", i), {16'd0, bit_count}, {16'd0, vecs[i].bcnt});
            chk($sformatf("vec%0d_ready", i), {31'd0, pl_if.payload_ready}, 32'd1);
        end

        // alternating, period 31; a mid-run period change must be ignored
        go_idle();
        start_run(SRC_ALT, 5'd31, 9'd0);
        sym_period = 5'd5;
        for (int k = 1; k <= 4; k++) begin
            wait_strobe(40, cyc);
            chk($sformatf("alt_spacing%0d", k), cyc, 32);
            chk($sformatf("alt_bit%0d", k), {31'd0, data_mod}, {31'd0, logic'(k % 2)});
            chk($sformatf("alt_bcnt%0d", k), {16'd0, bit_count}, k);
        end

        // PRBS9 with seed 0 -> 9'h1FF, one bit per clock, beyond one full period
        go_idle();
        start_run(SRC_PRBS9, 5'd0, 9'd0);
        m = 9'h1FF;
        for (int i = 0; i < 530; i++) begin
            tick();
            chk($sformatf("prbs_bit%0d", i), {31'd0, sym_strobe & data_mod}, {31'd0, m[8]});
            m = {m[7:0], m[8] ^ m[4]};
        end
        chk("prbs_bcnt", {16'd0, bit_count}, 32'd530);

        // payload word offered in IDLE, shifted out MSB first at period 3
        go_idle();
        word                = 32'hA500_0000;
        pl_if.payload       = word;
        pl_if.payload_valid = 1'b1;
        tick();
        pl_if.payload_valid = 1'b0;
        chk("pl_ready_after_accept", {31'd0, pl_if.payload_ready}, 32'd0);
        start_run(SRC_PAYLOAD, 5'd3, 9'd0);
        chk("pl_ready_after_load", {31'd0, pl_if.payload_ready}, 32'd1);
        for (int i = 0; i < 32; i++) begin
            wait_strobe(8, cyc);
            chk($sformatf("pl_spacing%0d", i), cyc, 4);
            chk($sformatf("pl_bit%0d", i), {31'd0, data_mod}, {31'd0, word[31-i]});
            chk($sformatf("pl_uf%0d", i), {31'd0, underflow}, 32'd0);
        end
        wait_strobe(8, cyc);
        chk("pl_uf_spacing", cyc, 4);
        chk("pl_uf_data_mod", {31'd0, data_mod}, 32'd0);
        chk("pl_uf_set", {31'd0, underflow}, 32'd1);

        // lock loss on the edge a strobe is due, then relock
        go_idle();
        start_run(SRC_ALT, 5'd3, 9'd0);
        wait_strobe(8, cyc);
        chk("lk_first_spacing", cyc, 4);
        tick();
        tick();
        tick();
        lock = 1'b0;
        tick();
        chk("lk_drop_busy", {31'd0, busy}, 32'd0);
        chk("lk_drop_strobe", {31'd0, sym_strobe}, 32'd0);
        chk("lk_drop_data_mod", {31'd0, data_mod}, 32'd0);
        nstrobe = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (sym_strobe || busy) nstrobe++;
        end
        chk("lk_unlocked_quiet", nstrobe, 0);
        lock = 1'b1;
        tick();
        chk("lk_relock_busy", {31'd0, busy}, 32'd1);
        wait_strobe(8, cyc);
        chk("lk_relock_spacing", cyc, 4);
        chk("lk_relock_bcnt", {16'd0, bit_count}, 32'd1);
        chk("lk_relock_bit", {31'd0, data_mod}, 32'd1);

        // reset mid-RUN with a word pending in holding
        go_idle();
        start_run(SRC_PAYLOAD, 5'd0, 9'd0);
        tick();
        chk("rr_uf_pre", {31'd0, underflow}, 32'd1);
        chk("rr_dm_pre", {31'd0, data_mod}, 32'd0);
        pl_if.payload       = 32'hFFFF_FFFF;
        pl_if.payload_valid = 1'b1;
        tick();
        pl_if.payload_valid = 1'b0;
        tick();
        chk("rr_ready_after_xfer", {31'd0, pl_if.payload_ready}, 32'd1);
        pl_if.payload       = 32'h1234_5678;
        pl_if.payload_valid = 1'b1;
        tick();
        pl_if.payload_valid = 1'b0;
        tick();
        chk("rr_ready_pending", {31'd0, pl_if.payload_ready}, 32'd0);
        chk("rr_busy_pre", {31'd0, busy}, 32'd1);
        chk("rr_data_mod_pre", {31'd0, data_mod}, 32'd1);
        rst = 1'b0;
        tick();
        chk("rr_data_mod", {31'd0, data_mod}, 32'd0);
        chk("rr_strobe", {31'd0, sym_strobe}, 32'd0);
        chk("rr_busy", {31'd0, busy}, 32'd0);
        chk("rr_underflow", {31'd0, underflow}, 32'd0);
        chk("rr_bit_count", {16'd0, bit_count}, 32'd0);
        chk("rr_ready", {31'd0, pl_if.payload_ready}, 32'd1);
        rst = 1'b1;
        tick();
        chk("rr_after_busy", {31'd0, busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adpll_mod_gen.md
# adpll_mod_gen

Synthesizable transmit-modulation data source for the ADPLL controller. It emits the data_mod bit that drives the ADPLL TX path, one symbol every programmable number of clk cycles, and only while the loop is in TX mode and channel lock is asserted. The data source is selectable: zero, alternating, PRBS9, or CPU-loaded payload words through a valid/ready double buffer. It sits between the CPU register file and adpll_ctr's data_mod input.

## Interface
- SYM_CNT_W, 5, width of symbol-period counter (default gives up to 32 clk per symbol)
- DATA_W, 32, payload word width, shifted MSB first
- BCNT_W, 16, width of bit_count
- clk  in  1  system clock (32 MHz in the ADPLL)
- rst  in  1  reset, synchronous, active-low
- en  in  1  block enable
- adpll_mode  in  2  PD=0, TEST=1, RX=2, TX=3
- channel_lock  in  1  ADPLL lock indication
- sym_period  in  SYM_CNT_W  clocks per symbol minus 1
- src_sel  in  2  0=zero, 1=alternating, 2=PRBS9, 3=payload
- seed  in  9  PRBS9 seed
- payload  in  DATA_W  payload word
- payload_valid  in  1  payload word offered
- payload_ready  out  1  holding register empty
- data_mod  out  1  modulation bit (registered)
- sym_strobe  out  1  one-cycle pulse on each data_mod update
- busy  out  1  state is RUN
- underflow  out  1  sticky: payload exhausted in RUN
- bit_count  out  BCNT_W  symbols emitted since RUN entry

## Operation
- States:
  - IDLE: en=0 or adpll_mode!=TX.
  - ARM: enabled, in TX, channel_lock=0.
  - RUN: enabled, in TX, locked.
- Transitions:
  - Any state goes to IDLE when en=0 or mode!=TX.
  - IDLE goes to ARM when en=1 and mode=TX.
  - ARM goes to RUN when channel_lock=1.
  - RUN goes to ARM when channel_lock=0.
  - IDLE has priority over ARM.
- On RUN entry:
  - sym_period, src_sel and seed are latched. Later changes are ignored until the next entry.
  - sym_cnt=0, bit_count=0, underflow=0.
  - LFSR loads seed; seed 0 is replaced by 9'h1FF.
  - Alternating state resets so that its first bit is 1.
- In RUN:
  - sym_cnt increments each cycle.
  - When sym_cnt==latched period: sym_cnt<=0, sym_strobe<=1, data_mod<=next bit, bit_count+1 (wraps to 0 after all-ones).
- Next bit per source:
  - zero: 0.
  - alternating: 1,0,1,…
  - PRBS9: x^9+x^5+1, output lfsr[8], advance one step per strobe.
  - payload: shift-register MSB.
- Payload buffering:
  - The holding register accepts payload when payload_valid && payload_ready, in any state.
  - The shift register loads from the holding register when it is empty and holding is full, either the same cycle or at a strobe consuming the last bit.
  - If the shift register is empty at a strobe: data_mod<=0, underflow<=1.
- Leaving RUN (to ARM or IDLE):
  - data_mod<=0, sym_strobe<=0, sym_cnt<=0.
  - Remaining shift-register bits are discarded; the holding register is retained.

## Timing
- All outputs are registered.
- Reset values: data_mod=0, sym_strobe=0, busy=0, underflow=0, bit_count=0, payload_ready=1. Buffers are emptied and the state goes to IDLE.
- Latency:
  - The first strobe occurs (latched period + 1) cycles after the RUN-entry edge; strobes then repeat at that period.
  - sym_period=0 gives one symbol per cycle.
- data_mod, sym_strobe and bit_count update on the same edge.
- Lock loss and mode change act on the next edge. A strobe that is due on that edge is suppressed.
- payload_ready deasserts on the edge after acceptance. It reasserts on the edge after holding moves into the shift register.
- Simultaneous accept and transfer, with holding previously full: the transfer happens first and the new word lands in holding in the same edge.
- A reset asserted mid-RUN overrides everything on the next edge.

## Structure
- Shared package adpll_pkg: mode constants PD/TEST/RX/TX, src_sel encodings, state enum {IDLE, ARM, RUN}, PRBS9 taps and default seed.
- One sub-module: adpll_prbs9. It provides a 9-bit LFSR with load, advance, and out=lfsr[8].
- The payload double buffer and the counter stay in the top level.

## Test plan
- TX, lock=1, src_sel=1, sym_period=31 -> first strobe 32 clk after RUN entry; data_mod 1,0,1,0 at 32-clk spacing; bit_count 1,2,3,4.
- src_sel=2, seed=0, sym_period=0 -> one bit per clk matching a golden PRBS9 seeded with 9'h1FF; the sequence repeats after 511 bits.
- src_sel=3, one word 32'hA5000000, sym_period=3 -> bits 1,0,1,0,0,1,0,1 then zeros at 4-clk spacing. payload_ready returns to 1 one cycle after load. After 32 bits with no second word -> underflow=1 and data_mod=0.
- channel_lock dropped mid-RUN -> next edge busy=0, data_mod=0, no strobes. Lock restored -> first strobe period+1 clk later and bit_count restarts at 1.
- rst=0 during RUN with payload pending -> next edge all outputs at reset values and payload_ready=1.
- adpll_mode=RX with lock=1 and en=1 -> state stays IDLE, no strobes, data_mod=0.
